// File: rtl/req_arbiter8_if.sv
// Request/grant bundle between requesting units and the 8-way arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants.
interface req_arbiter8_if;
  logic       ena;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       any_req;

  modport master (
    output ena, req,
    input  gnt, gnt_id, gnt_valid, any_req
  );

  modport slave (
    input  ena, req,
    output gnt, gnt_id, gnt_valid, any_req
  );
endinterface

// File: rtl/req_arbiter8.sv
// 8-way arbiter for one shared port: fixed or round-robin priority,
// registered one-hot grant held per tenure up to a quantum of cycles.
module req_arbiter8 #(
  parameter int          RR_EN   = 1,
  parameter int unsigned QUANTUM = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  req_arbiter8_if.slave  bus
);

  localparam int QW =
    (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
  localparam logic [QW-1:0] QLAST =
    QW'((QUANTUM > 0) ? QUANTUM - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t          state;
  logic [2:0]      last_id;
  logic [QW-1:0]   hold_cnt;
  logic [2:0]      start;
  logic [2:0]      idx;
  logic [2:0]      win;
  logic            found;
  logic            q_hit;
  logic            done;

  assign bus.any_req = |bus.req;

  // Descending search from start, wrapping 0 -> 7.
  always_comb begin
    start = (RR_EN != 0) ? last_id - 3'd1 : 3'd7;
    idx   = start;
    win   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start - 3'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign q_hit = (QUANTUM != 0) && (hold_cnt == QLAST);
  assign done  = !bus.req[bus.gnt_id] || q_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.gnt       <= 8'h00;
      bus.gnt_id    <= 3'd0;
      bus.gnt_valid <= 1'b0;
      last_id       <= 3'd0;
      hold_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE, GAP: begin
          if (bus.ena && found) begin
            state         <= GRANT;
            bus.gnt       <= 8'h01 << win;
            bus.gnt_id    <= win;
            bus.gnt_valid <= 1'b1;
            hold_cnt      <= '0;
          end else begin
            state         <= IDLE;
            bus.gnt       <= 8'h00;
            bus.gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (done) begin
            state         <= GAP;
            bus.gnt       <= 8'h00;
            bus.gnt_valid <= 1'b0;
            last_id       <= bus.gnt_id;
          end else begin
            hold_cnt <= hold_cnt + QW'(1);
          end
        end
        default: begin
          state         <= IDLE;
          bus.gnt       <= 8'h00;
          bus.gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8: fixed priority, quantum limit,
// round-robin rotation, ena gating and asynchronous reset.
module tb_req_arbiter8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  req_arbiter8_if ia ();
  req_arbiter8_if ib ();
  req_arbiter8_if ic ();

  req_arbiter8 #(.RR_EN(0), .QUANTUM(16)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  req_arbiter8 #(.RR_EN(0), .QUANTUM(4)) u_q4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  req_arbiter8 #(.RR_EN(1), .QUANTUM(2)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ic.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] eid;
    logic [7:0] one;
    n_checks = 0;
    n_fail   = 0;
    one      = 8'h01;
    rst_n    = 1'b0;
    ia.ena = 1'b0; ia.req = 8'h00;
    ib.ena = 1'b0; ib.req = 8'h00;
    ic.ena = 1'b0; ic.req = 8'h00;
    repeat (2) tick();
    check("rst_gnt", 32'(ia.gnt), 32'h00);
    check("rst_id", 32'(ia.gnt_id), 32'd0);
    check("rst_vld", 32'(ia.gnt_valid), 32'd0);
    check("rst_any", 32'(ia.any_req), 32'd0);
    check("rst_rr_gnt", 32'(ic.gnt), 32'h00);
    rst_n = 1'b1;
    tick();

    // fixed priority, highest index wins
    ia.ena = 1'b1;
    ia.req = 8'h24;
    tick();
    check("t1_gnt", 32'(ia.gnt), 32'h20);
    check("t1_id", 32'(ia.gnt_id), 32'd5);
    check("t1_vld", 32'(ia.gnt_valid), 32'd1);
    check("t1_any", 32'(ia.any_req), 32'd1);
    repeat (2) begin
      tick();
      check("t1_hold", 32'(ia.gnt), 32'h20);
    end

    // drop req[5]: one GAP cycle then requester 2
    ia.req = 8'h04;
    tick();
    check("t2_gap", 32'(ia.gnt), 32'h00);
    check("t2_gap_vld", 32'(ia.gnt_valid), 32'd0);
    check("t2_gap_id", 32'(ia.gnt_id), 32'd5);
    tick();
    check("t2_gnt", 32'(ia.gnt), 32'h04);
    check("t2_id", 32'(ia.gnt_id), 32'd2);
    ia.req = 8'h00;
    tick();
    check("t2_end", 32'(ia.gnt), 32'h00);
    check("t2_any0", 32'(ia.any_req), 32'd0);
    tick();

    // ena gates new grants only
    ia.ena = 1'b0;
    ia.req = 8'h81;
    tick();
    check("t5_any", 32'(ia.any_req), 32'd1);
    check("t5_nognt", 32'(ia.gnt), 32'h00);
    tick();
    check("t5_nognt2", 32'(ia.gnt_valid), 32'd0);
    ia.ena = 1'b1;
    tick();
    check("t5_gnt", 32'(ia.gnt), 32'h80);
    check("t5_id", 32'(ia.gnt_id), 32'd7);
    ia.ena = 1'b0;
    repeat (3) begin
      tick();
      check("t5_hold", 32'(ia.gnt), 32'h80);
    end
    ia.req = 8'h01;
    tick();
    check("t5_drop", 32'(ia.gnt), 32'h00);
    tick();
    check("t5_idle", 32'(ia.gnt), 32'h00);
    ia.req = 8'h00;
    tick();

    // quantum of 4 with a constant request
    ib.ena = 1'b1;
    ib.req = 8'h08;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t3_q4", 32'(ib.gnt),
            ((k - 1) % 5 < 4) ? 32'h08 : 32'h00);
    end
    ib.req = 8'h00;
    tick();

    // round-robin over all requesters
    ic.ena = 1'b1;
    ic.req = 8'hFF;
    for (int t = 0; t < 9; t++) begin
      eid = 3'(7 - (t % 8));
      for (int k = 0; k < 3; k++) begin
        tick();
        if (k < 2) begin
          check("t4_rr_id", 32'(ic.gnt_id), 32'(eid));
          check("t4_rr_gnt", 32'(ic.gnt),
                32'(one << eid));
        end else begin
          check("t4_rr_gap", 32'(ic.gnt), 32'h00);
        end
      end
    end
    ic.req = 8'h00;
    tick();

    // asynchronous reset mid-tenure
    ia.ena = 1'b1;
    ia.req = 8'h02;
    tick();
    check("t6_gnt", 32'(ia.gnt), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_gnt", 32'(ia.gnt), 32'h00);
    check("t6_async_vld", 32'(ia.gnt_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_regnt", 32'(ia.gnt), 32'h02);
    check("t6_id", 32'(ia.gnt_id), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
